prog_clock_divider: RTL
=======================

Name: prog_clock_divider

Overview:
- Runtime-programmable clock divider; successor to the fixed, even-only divide-by-N generator.
- Adds odd divisors, a divisor update that is applied only at a period boundary so no glitch or runt phase is produced, a glitch-free enable/stop, and single-cycle edge strobes.
- Derived serial clocks (attenuator SPI-style buses, sample strobes) are built from its outputs.
- All logic runs on the posedge of one clock; o_clk is a registered output.

Parameters:
- CNT_WIDTH, 16, width of the divisor and of the internal counter.
- DEFAULT_DIV, 10, divisor loaded at reset; must satisfy 2 <= DEFAULT_DIV <= 2^CNT_WIDTH-1.

Ports:
- i_clk  in  1  source clock; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  level; high = generate, low = stop at the end of the current period.
- i_div  in  CNT_WIDTH  new divisor N, sampled when i_div_load=1.
- i_div_load  in  1  one-cycle request to load i_div.
- o_div_ack  out  1  one-cycle pulse in the first cycle that the new divisor governs.
- o_clk  out  1  divided clock.
- o_rise  out  1  high exactly in the cycle o_clk first reads 1 in each period.
- o_fall  out  1  high exactly in the cycle o_clk first reads 0 after a high phase.
- o_active  out  1  high while the divider is running.

Behaviour:
- Reset (i_rst=1 at posedge):
  - o_clk=0, o_rise=0, o_fall=0, o_div_ack=0, o_active=0.
  - cnt=0, div=DEFAULT_DIV, pending flag cleared.
  - Reset mid-period truncates immediately; no completion of the current phase.
- Divisor clamp: an effective N of 0 or 1 is treated as 2. The clamped value is what is stored.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - o_clk=0, cnt=0, o_active=0.
  - i_en sampled 1 -> RUN. At that edge cnt<=0, o_clk<=0, o_active<=1.
- RUN:
  - Each edge: cnt <= (cnt==N-1) ? 0 : cnt+1.
  - o_clk <= (cnt_next >= floor(N/2)).
  - Period = N cycles: low phase floor(N/2) cycles, then high phase ceil(N/2) cycles. Odd N therefore has the extra cycle in the high phase.
- Edge strobes:
  - o_rise is registered alongside o_clk: 1 when o_clk goes 0->1.
  - o_fall: 1 when o_clk goes 1->0, including the final fall when stopping.
- Period boundary = the edge at which cnt wraps N-1 -> 0.
- Divisor load:
  - i_div_load=1 captures the clamped i_div into a pending register and sets the pending flag.
  - RUN: applied at the next period boundary. That edge uses the new N for the o_clk computation, and o_div_ack=1 in the following cycle (the first cycle of the new period).
  - IDLE: applied at the next edge, with o_div_ack=1 in the cycle after that.
  - A second load before application overwrites the pending value; only one ack is produced.
  - A load in the same cycle as a boundary takes effect at the following boundary.
- Stop:
  - i_en=0 while in RUN -> STOPPING. Counting continues until the period boundary, where o_clk<=0, cnt<=0, o_active<=0 and the state goes to IDLE.
  - If i_en returns to 1 while STOPPING, the state goes back to RUN and the period is not interrupted.
  - A pending load is applied at the same boundary and acked.
- No output ever shows a high or low phase shorter than the phase its governing N defines.

Test Plan:
- Reset, DEFAULT_DIV=10, i_en=1 -> o_clk pattern repeats 5 low / 5 high; o_rise is 1 on cycles 5, 15, 25 after enable; o_fall is 1 on cycles 10, 20.
- Load i_div=5 while idle, then enable -> ack 2 cycles after the load; o_clk repeats 2 low / 3 high; period 5.
- Load i_div=0 and i_div=1 -> behaves as N=2: alternating 1 low / 1 high; o_rise and o_fall alternate every cycle.
- Running N=10, load i_div=4 at cnt=3 -> the current 10-cycle period completes unaltered; ack in the first cycle of the new period; then 2 low / 2 high. A second load of 6 before the boundary -> only 6 is applied, one ack.
- Running N=8, drop i_en during the high phase -> the high phase completes its full 4 cycles; o_fall fires; o_active=0; o_clk held 0. Raise i_en -> a fresh 4-low phase starts.
- Assert i_rst mid-high phase -> the next cycle has all outputs 0 and div=DEFAULT_DIV; a pending load is discarded and no ack is produced.

Source files
------------

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider. Supports odd divisors, divisor updates
// that take effect only at a period boundary, a glitch-free stop, and edge strobes.
module prog_clock_divider #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_div,
  input  logic                 i_div_load,
  output logic                 o_div_ack,
  output logic                 o_clk,
  output logic                 o_rise,
  output logic                 o_fall,
  output logic                 o_active
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DIV_RESET = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] DIV_MIN   = CNT_WIDTH'(2);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] div;
  logic [CNT_WIDTH-1:0] pend_div;
  logic                 pend_flag;

  logic [CNT_WIDTH-1:0] div_clamped;
  logic [CNT_WIDTH-1:0] div_eff;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 at_boundary;
  logic                 apply_pend;
  logic                 clk_next;

  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    div_clamped = (i_div < DIV_MIN) ? DIV_MIN : i_div;
    at_boundary = (state != IDLE) && (cnt == div - 1'b1);
    // A pending divisor lands at the wrap edge while running, or at the very next edge when idle.
    apply_pend  = pend_flag && ((state == IDLE) || at_boundary);
    div_eff     = apply_pend ? pend_div : div;
    cnt_next    = ((state == IDLE) || at_boundary) ? '0 : cnt + 1'b1;
    clk_next    = (cnt_next >= (div_eff >> 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      div       <= DIV_RESET;
      pend_div  <= DIV_RESET;
      pend_flag <= 1'b0;
      o_clk     <= 1'b0;
      o_rise    <= 1'b0;
      o_fall    <= 1'b0;
      o_div_ack <= 1'b0;
      o_active  <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      o_clk     <= clk_next;
      o_rise    <= ~o_clk & clk_next;
      o_fall    <= o_clk & ~clk_next;
      o_div_ack <= apply_pend;

      if (apply_pend) div <= pend_div;

      // A load coinciding with an application is kept pending for the next boundary.
      if (i_div_load) begin
        pend_div  <= div_clamped;
        pend_flag <= 1'b1;
      end else if (apply_pend) begin
        pend_flag <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (i_en) begin
            state    <= RUN;
            o_active <= 1'b1;
          end
        end
        RUN, STOPPING: begin
          if (i_en) begin
            state <= RUN;
          end else if (at_boundary) begin
            state    <= IDLE;
            o_active <= 1'b0;
          end else begin
            state <= STOPPING;
          end
        end
        default: begin
          state    <= IDLE;
          o_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
